// File: rtl/y86_pkg.sv
// Shared Y86 register-file constants: architectural register IDs, the
// "no register" encoding and the default register-file geometry.
package y86_pkg;

  localparam logic [3:0] EAX   = 4'd0;
  localparam logic [3:0] ECX   = 4'd1;
  localparam logic [3:0] EDX   = 4'd2;
  localparam logic [3:0] EBX   = 4'd3;
  localparam logic [3:0] ESP   = 4'd4;
  localparam logic [3:0] EBP   = 4'd5;
  localparam logic [3:0] ESI   = 4'd6;
  localparam logic [3:0] EDI   = 4'd7;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NREGS  = 8;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for the pipelined register file. Exposes the
// post-update busy state of two register IDs so the read flops can capture it.
module regfile_scoreboard
  import y86_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = DEF_NREGS
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claimE,
  input  logic [ADDR_W-1:0] claimM,
  input  logic [ADDR_W-1:0] tapA,
  input  logic [ADDR_W-1:0] tapB,
  output logic              busy_nxtA,
  output logic              busy_nxtB
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [NREGS-1:0] set_s;
  logic [NREGS-1:0] clr_s;

  // Next busy state per register; a claim is a newer producer, so set beats clear.
  // IDs >= NREGS match no index and therefore never set, clear or tap anything.
  always_comb begin
    set_s      = '0;
    clr_s      = '0;
    busy_nxt_s = '0;
    busy_nxtA  = 1'b0;
    busy_nxtB  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      set_s[i]      = claim_en && ((claimE == ADDR_W'(i)) || (claimM == ADDR_W'(i)));
      clr_s[i]      = (dstE == ADDR_W'(i)) || (dstM == ADDR_W'(i));
      busy_nxt_s[i] = set_s[i] || (busy_r[i] && !clr_s[i]);
      busy_nxtA     = (tapA == ADDR_W'(i)) ? busy_nxt_s[i] : busy_nxtA;
      busy_nxtB     = (tapB == ADDR_W'(i)) ? busy_nxt_s[i] : busy_nxtB;
    end
  end

  // Busy bit storage.
  always_ff @(posedge CLK) begin
    if (reset) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

endmodule

// File: rtl/regfile_pipe.sv
// Pipelined Y86 register file: two registered read ports with write-first
// bypass (M over E over storage), two write ports and a busy scoreboard.
module regfile_pipe
  import y86_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = DEF_NREGS
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [WIDTH-1:0]  valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [WIDTH-1:0]  valM,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claimE,
  input  logic [ADDR_W-1:0] claimM,
  output logic [WIDTH-1:0]  valA,
  output logic [WIDTH-1:0]  valB,
  output logic              busyA,
  output logic              busyB
);

  logic [WIDTH-1:0] regs_r [NREGS];
  logic [WIDTH-1:0] stor_a_s;
  logic [WIDTH-1:0] stor_b_s;
  logic [WIDTH-1:0] byp_a_s;
  logic [WIDTH-1:0] byp_b_s;
  logic             busy_nxt_a_s;
  logic             busy_nxt_b_s;

  function automatic logic in_range(input logic [ADDR_W-1:0] id);
    return (32'(id) < NREGS);
  endfunction

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .CLK       (CLK),
    .reset     (reset),
    .dstE      (dstE),
    .dstM      (dstM),
    .claim_en  (claim_en),
    .claimE    (claimE),
    .claimM    (claimM),
    .tapA      (srcA),
    .tapB      (srcB),
    .busy_nxtA (busy_nxt_a_s),
    .busy_nxtB (busy_nxt_b_s)
  );

  // Storage update; on a same-register collision the M port wins (popl %esp).
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (dstM == ADDR_W'(i)) begin
          regs_r[i] <= valM;
        end else if (dstE == ADDR_W'(i)) begin
          regs_r[i] <= valE;
        end
      end
    end
  end

  // Stored-value muxes; an out-of-range ID matches nothing and reads as zero.
  always_comb begin
    stor_a_s = '0;
    stor_b_s = '0;
    for (int i = 0; i < NREGS; i++) begin
      stor_a_s = (srcA == ADDR_W'(i)) ? regs_r[i] : stor_a_s;
      stor_b_s = (srcB == ADDR_W'(i)) ? regs_r[i] : stor_b_s;
    end
  end

  // Write-first bypass: data being written this edge is visible to this read.
  always_comb begin
    byp_a_s = '0;
    byp_b_s = '0;
    if (!in_range(srcA)) begin
      byp_a_s = '0;
    end else if (dstM == srcA) begin
      byp_a_s = valM;
    end else if (dstE == srcA) begin
      byp_a_s = valE;
    end else begin
      byp_a_s = stor_a_s;
    end
    if (!in_range(srcB)) begin
      byp_b_s = '0;
    end else if (dstM == srcB) begin
      byp_b_s = valM;
    end else if (dstE == srcB) begin
      byp_b_s = valE;
    end else begin
      byp_b_s = stor_b_s;
    end
  end

  // Output flops: capture on rd_en, otherwise hold.
  always_ff @(posedge CLK) begin
    if (reset) begin
      valA  <= '0;
      valB  <= '0;
      busyA <= 1'b0;
      busyB <= 1'b0;
    end else if (rd_en) begin
      valA  <= byp_a_s;
      valB  <= byp_b_s;
      busyA <= busy_nxt_a_s;
      busyB <= busy_nxt_b_s;
    end
  end

endmodule
